// File: rtl/rv32i_pkg.sv
// Shared widths, ALU opcodes and the execute-stage control bundle for the RV32I pipeline.
package rv32i_pkg;

    localparam int XLEN    = 32;
    localparam int ALUOP_W = 4;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd6;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd7;
    localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'd8;
    localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'd9;

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic               jump;
    } ex_ctrl_t;

endpackage

// File: rtl/rv32i_skid_buf.sv
// Two-slot skid buffer: a main output slot plus one overflow slot, with synchronous flush.
module rv32i_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Handshake: a beat moves on a port only in a cycle where valid & ready are both
    // high at the clock edge; a producer seeing ready=0 must hold valid and data steady.
    logic             r_main_valid;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;

    logic             w_accept;
    logic             w_xfer;
    logic             w_main_valid_nxt;
    logic             w_skid_valid_nxt;
    logic [WIDTH-1:0] w_main_data_nxt;
    logic [WIDTH-1:0] w_skid_data_nxt;

    assign w_accept = in_valid & r_in_ready;
    assign w_xfer   = r_main_valid & out_ready;

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_main_data_nxt  = r_main_data;
        w_skid_data_nxt  = r_skid_data;
        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (!r_main_valid || w_xfer) begin
            // Skid full implies in_ready was low, so no accept can collide here.
            if (r_skid_valid) begin
                w_main_data_nxt  = r_skid_data;
                w_main_valid_nxt = 1'b1;
                w_skid_valid_nxt = 1'b0;
            end else if (w_accept) begin
                w_main_data_nxt  = in_data;
                w_main_valid_nxt = 1'b1;
            end else begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_data_nxt  = in_data;
            w_skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
            r_main_data  <= '0;
            r_skid_data  <= '0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
            r_main_data  <= w_main_data_nxt;
            r_skid_data  <= w_skid_data_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;

endmodule

// File: rtl/rv32i_id_ex_reg.sv
// ID/EX pipeline register: packs decode fields into one vector held by a two-slot skid buffer.
module rv32i_id_ex_reg
    import rv32i_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_rs1_data,
    input  logic [XLEN-1:0]    in_rs2_data,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [4:0]         in_rd,
    input  logic [ALUOP_W-1:0] in_alu_op,
    input  logic               in_alu_src,
    input  logic               in_reg_write,
    input  logic               in_mem_read,
    input  logic               in_mem_write,
    input  logic               in_branch,
    input  logic               in_jump,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_rs1_data,
    output logic [XLEN-1:0]    out_rs2_data,
    output logic [XLEN-1:0]    out_imm,
    output logic [4:0]         out_rd,
    output logic [ALUOP_W-1:0] out_alu_op,
    output logic               out_alu_src,
    output logic               out_reg_write,
    output logic               out_mem_read,
    output logic               out_mem_write,
    output logic               out_branch,
    output logic               out_jump
);

    localparam int PAYLOAD_W = 4 * XLEN + 5 + $bits(ex_ctrl_t);

    ex_ctrl_t               w_in_ctrl;
    ex_ctrl_t               w_out_ctrl;
    logic [PAYLOAD_W-1:0]   w_in_data;
    logic [PAYLOAD_W-1:0]   w_out_data;

    // A write to x0 is architecturally discarded, so drop it before it is stored.
    always_comb begin
        w_in_ctrl           = '0;
        w_in_ctrl.alu_op    = in_alu_op;
        w_in_ctrl.alu_src   = in_alu_src;
        w_in_ctrl.reg_write = in_reg_write & (in_rd != 5'd0);
        w_in_ctrl.mem_read  = in_mem_read;
        w_in_ctrl.mem_write = in_mem_write;
        w_in_ctrl.branch    = in_branch;
        w_in_ctrl.jump      = in_jump;
    end

    assign w_in_data = {in_pc, in_rs1_data, in_rs2_data, in_imm, in_rd, w_in_ctrl};

    rv32i_skid_buf #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_data)
    );

    assign {out_pc, out_rs1_data, out_rs2_data, out_imm, out_rd, w_out_ctrl} = w_out_data;

    assign out_alu_op  = w_out_ctrl.alu_op;
    assign out_alu_src = w_out_ctrl.alu_src;

    // Side-effecting controls are masked whenever the slot is empty, which covers flush.
    assign out_reg_write = w_out_ctrl.reg_write & out_valid;
    assign out_mem_read  = w_out_ctrl.mem_read  & out_valid;
    assign out_mem_write = w_out_ctrl.mem_write & out_valid;
    assign out_branch    = w_out_ctrl.branch    & out_valid;
    assign out_jump      = w_out_ctrl.jump      & out_valid;

endmodule

// File: tb/tb_rv32i_id_ex_reg.sv
// Directed bench for the ID/EX register: reset, streaming, backpressure, flush, x0 and async reset.
module tb_rv32i_id_ex_reg;
    import rv32i_pkg::*;

    logic               clk;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    in_pc;
    logic [XLEN-1:0]    in_rs1_data;
    logic [XLEN-1:0]    in_rs2_data;
    logic [XLEN-1:0]    in_imm;
    logic [4:0]         in_rd;
    logic [ALUOP_W-1:0] in_alu_op;
    logic               in_alu_src;
    logic               in_reg_write;
    logic               in_mem_read;
    logic               in_mem_write;
    logic               in_branch;
    logic               in_jump;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_pc;
    logic [XLEN-1:0]    out_rs1_data;
    logic [XLEN-1:0]    out_rs2_data;
    logic [XLEN-1:0]    out_imm;
    logic [4:0]         out_rd;
    logic [ALUOP_W-1:0] out_alu_op;
    logic               out_alu_src;
    logic               out_reg_write;
    logic               out_mem_read;
    logic               out_mem_write;
    logic               out_branch;
    logic               out_jump;

    int n_checks;
    int n_pass;

    rv32i_id_ex_reg dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_rs1_data   (in_rs1_data),
        .in_rs2_data   (in_rs2_data),
        .in_imm        (in_imm),
        .in_rd         (in_rd),
        .in_alu_op     (in_alu_op),
        .in_alu_src    (in_alu_src),
        .in_reg_write  (in_reg_write),
        .in_mem_read   (in_mem_read),
        .in_mem_write  (in_mem_write),
        .in_branch     (in_branch),
        .in_jump       (in_jump),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_rs1_data  (out_rs1_data),
        .out_rs2_data  (out_rs2_data),
        .out_imm       (out_imm),
        .out_rd        (out_rd),
        .out_alu_op    (out_alu_op),
        .out_alu_src   (out_alu_src),
        .out_reg_write (out_reg_write),
        .out_mem_read  (out_mem_read),
        .out_mem_write (out_mem_write),
        .out_branch    (out_branch),
        .out_jump      (out_jump)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_instr(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] rs2,
                               input logic [XLEN-1:0] imm, input logic [4:0] rd,
                               input logic [ALUOP_W-1:0] op, input logic src,
                               input logic rw, input logic mr, input logic mw);
        in_valid     = 1'b1;
        in_pc        = pc;
        in_rs1_data  = pc ^ 32'h1111_0000;
        in_rs2_data  = rs2;
        in_imm       = imm;
        in_rd        = rd;
        in_alu_op    = op;
        in_alu_src   = src;
        in_reg_write = rw;
        in_mem_read  = mr;
        in_mem_write = mw;
        in_branch    = 1'b0;
        in_jump      = 1'b0;
    endtask

    task automatic drive_idle();
        in_valid = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b1;
        flush        = 1'b0;
        out_ready    = 1'b0;
        in_valid     = 1'b0;
        in_pc        = '0;
        in_rs1_data  = '0;
        in_rs2_data  = '0;
        in_imm       = '0;
        in_rd        = '0;
        in_alu_op    = '0;
        in_alu_src   = 1'b0;
        in_reg_write = 1'b0;
        in_mem_read  = 1'b0;
        in_mem_write = 1'b0;
        in_branch    = 1'b0;
        in_jump      = 1'b0;

        // reset then idle
        repeat (3) step();
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_out_imm", 64'(out_imm), 64'd0);
        check("rst_out_rs2", 64'(out_rs2_data), 64'd0);
        check("rst_out_ctrl", 64'({out_alu_op, out_alu_src, out_reg_write, out_mem_read,
                                   out_mem_write, out_branch, out_jump, out_rd}), 64'd0);
        step();
        check("rst_in_ready_after_edge", 64'(in_ready), 64'd1);

        // streaming: four ADDI, each visible one edge after acceptance
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_instr(32'h10 + 32'(4 * i), 32'h0, 32'h5 + 32'(i), 5'd1, ALU_ADD,
                        1'b1, 1'b1, 1'b0, 1'b0);
            step();
            check($sformatf("stream_valid_%0d", i), 64'(out_valid), 64'd1);
            check($sformatf("stream_imm_%0d", i), 64'(out_imm), 64'h5 + 64'(i));
            check($sformatf("stream_pc_%0d", i), 64'(out_pc), 64'h10 + 64'(4 * i));
            check($sformatf("stream_in_ready_%0d", i), 64'(in_ready), 64'd1);
        end
        check("stream_alu_src", 64'(out_alu_src), 64'd1);
        check("stream_reg_write", 64'(out_reg_write), 64'd1);
        check("stream_rd", 64'(out_rd), 64'd1);
        drive_idle();
        step();
        check("stream_drained", 64'(out_valid), 64'd0);

        // backpressure: main holds 0x100, skid takes 0x104, decode holds 0x108
        drive_instr(32'h100, 32'h0, 32'h0, 5'd2, ALU_SUB, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        out_ready = 1'b0;
        drive_instr(32'h104, 32'h0, 32'h0, 5'd3, ALU_XOR, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("bp_main_pc", 64'(out_pc), 64'h100);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        drive_instr(32'h108, 32'h0, 32'h0, 5'd4, ALU_OR, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        check("bp_hold_pc", 64'(out_pc), 64'h100);
        check("bp_hold_op", 64'(out_alu_op), 64'(ALU_SUB));
        check("bp_still_not_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step();
        check("bp_drain_pc_104", 64'(out_pc), 64'h104);
        check("bp_drain_rd_104", 64'(out_rd), 64'd3);
        check("bp_ready_again", 64'(in_ready), 64'd1);
        step();
        check("bp_drain_pc_108", 64'(out_pc), 64'h108);
        check("bp_drain_valid_108", 64'(out_valid), 64'd1);
        drive_idle();
        step();
        check("bp_empty", 64'(out_valid), 64'd0);

        // flush with both slots full and an instruction on offer
        drive_instr(32'h200, 32'h0, 32'h0, 5'd5, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        out_ready = 1'b0;
        drive_instr(32'h204, 32'h0, 32'h0, 5'd6, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        check("fl_pre_pc", 64'(out_pc), 64'h200);
        check("fl_pre_in_ready", 64'(in_ready), 64'd0);
        drive_instr(32'h208, 32'h0, 32'h0, 5'd7, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_reg_write", 64'(out_reg_write), 64'd0);
        check("fl_mem_write", 64'(out_mem_write), 64'd0);
        check("fl_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        drive_instr(32'h300, 32'h0, 32'h0, 5'd8, ALU_AND, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("fl_after_pc", 64'(out_pc), 64'h300);
        check("fl_after_valid", 64'(out_valid), 64'd1);
        drive_idle();
        step();
        check("fl_after_alone", 64'(out_valid), 64'd0);

        // x0 destination suppresses reg_write but keeps data
        drive_instr(32'h400, 32'hDEAD_BEEF, 32'h0, 5'd0, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("x0_valid", 64'(out_valid), 64'd1);
        check("x0_reg_write", 64'(out_reg_write), 64'd0);
        check("x0_rs2", 64'(out_rs2_data), 64'hDEAD_BEEF);

        // store passes through unchanged
        drive_instr(32'h500, 32'h1234_5678, 32'h10, 5'd9, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        check("st_mem_write", 64'(out_mem_write), 64'd1);
        check("st_alu_src", 64'(out_alu_src), 64'd1);
        check("st_reg_write", 64'(out_reg_write), 64'd0);
        check("st_imm", 64'(out_imm), 64'h10);
        check("st_rs1", 64'(out_rs1_data), 64'h1111_0500);
        drive_idle();
        step();

        // asynchronous reset with both slots full
        out_ready = 1'b0;
        drive_instr(32'h600, 32'h0, 32'h0, 5'd10, ALU_SRA, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        drive_instr(32'h604, 32'h0, 32'h0, 5'd11, ALU_SRL, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        drive_idle();
        check("ar_pre_full", 64'(in_ready), 64'd0);
        check("ar_pre_mem_read", 64'(out_mem_read), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_out_valid", 64'(out_valid), 64'd0);
        check("ar_out_pc", 64'(out_pc), 64'd0);
        check("ar_out_rd", 64'(out_rd), 64'd0);
        check("ar_in_ready", 64'(in_ready), 64'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        check("ar_in_ready_back", 64'(in_ready), 64'd1);
        check("ar_no_survivor", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
